// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that funnels several APB requesters onto one downstream
// APB segment, replaying each latched transfer and bounding it with a timeout.
module apb_rr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int SW        = DATA_WIDTH / 8
) (
    input  logic                          pclk,
    input  logic                          preset_n,
    input  logic [NUM_REQ-1:0]            m_psel,
    input  logic [NUM_REQ-1:0]            m_penable,
    input  logic [NUM_REQ-1:0]            m_pwrite,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_paddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] m_pwdata,
    input  logic [NUM_REQ*SW-1:0]         m_pstrb,
    output logic [NUM_REQ-1:0]            m_pready,
    output logic [DATA_WIDTH-1:0]         m_prdata,
    output logic                          m_pslverr,
    output logic                          s_psel,
    output logic                          s_penable,
    output logic                          s_pwrite,
    output logic [ADDR_WIDTH-1:0]         s_paddr,
    output logic [DATA_WIDTH-1:0]         s_pwdata,
    output logic [SW-1:0]                 s_pstrb,
    input  logic [DATA_WIDTH-1:0]         s_prdata,
    input  logic                          s_pready,
    input  logic                          s_pslverr,
    output logic                          busy,
    output logic [GW-1:0]                 grant_idx,
    output logic                          timeout_pulse
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           ptr_q, ptr_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    s_psel_q, s_psel_d;
    logic                    s_penable_q, s_penable_d;
    logic                    s_pwrite_q, s_pwrite_d;
    logic [ADDR_WIDTH-1:0]   s_paddr_q, s_paddr_d;
    logic [DATA_WIDTH-1:0]   s_pwdata_q, s_pwdata_d;
    logic [SW-1:0]           s_pstrb_q, s_pstrb_d;
    logic [NUM_REQ-1:0]      m_pready_q, m_pready_d;
    logic [DATA_WIDTH-1:0]   m_prdata_q, m_prdata_d;
    logic                    m_pslverr_q, m_pslverr_d;
    logic                    busy_q, busy_d;
    logic                    timeout_pulse_q, timeout_pulse_d;

    logic                    found;
    logic [GW-1:0]           win_idx;
    int                      idx;
    logic                    win_write;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic [SW-1:0]           win_strb;

    // Requesters only ever see m_pready; their penable carries no arbitration meaning.
    logic unused_penable;
    assign unused_penable = ^m_penable;

    // Search starts at the pointer and wraps, so the last winner ranks lowest.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && m_psel[idx]) begin
                found   = 1'b1;
                win_idx = GW'(idx);
            end
        end
    end

    always_comb begin
        win_write = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        win_strb  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == GW'(k)) begin
                win_write = m_pwrite[k];
                win_addr  = m_paddr[k*ADDR_WIDTH +: ADDR_WIDTH];
                win_wdata = m_pwdata[k*DATA_WIDTH +: DATA_WIDTH];
                win_strb  = m_pstrb[k*SW +: SW];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        grant_d         = grant_q;
        count_d         = count_q;
        s_psel_d        = 1'b0;
        s_penable_d     = 1'b0;
        s_pwrite_d      = s_pwrite_q;
        s_paddr_d       = s_paddr_q;
        s_pwdata_d      = s_pwdata_q;
        s_pstrb_d       = s_pstrb_q;
        m_pready_d      = '0;
        m_prdata_d      = '0;
        m_pslverr_d     = 1'b0;
        timeout_pulse_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = SETUP;
                    grant_d    = win_idx;
                    s_psel_d   = 1'b1;
                    s_pwrite_d = win_write;
                    s_paddr_d  = win_addr;
                    s_pwdata_d = win_wdata;
                    s_pstrb_d  = win_strb;
                end
            end
            SETUP: begin
                state_d     = ACCESS;
                s_psel_d    = 1'b1;
                s_penable_d = 1'b1;
            end
            ACCESS: begin
                s_psel_d    = 1'b1;
                s_penable_d = 1'b1;
                count_d     = count_q + CW'(1);
                if (s_pready) begin
                    state_d     = DONE;
                    s_psel_d    = 1'b0;
                    s_penable_d = 1'b0;
                    m_pready_d  = NUM_REQ'(1) << grant_q;
                    m_prdata_d  = s_prdata;
                    m_pslverr_d = s_pslverr;
                end else if (count_q == CW'(TIMEOUT - 1)) begin
                    state_d         = DONE;
                    s_psel_d        = 1'b0;
                    s_penable_d     = 1'b0;
                    m_pready_d      = NUM_REQ'(1) << grant_q;
                    m_pslverr_d     = 1'b1;
                    timeout_pulse_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                count_d = '0;
                ptr_d   = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            grant_q         <= '0;
            count_q         <= '0;
            s_psel_q        <= 1'b0;
            s_penable_q     <= 1'b0;
            s_pwrite_q      <= 1'b0;
            s_paddr_q       <= '0;
            s_pwdata_q      <= '0;
            s_pstrb_q       <= '0;
            m_pready_q      <= '0;
            m_prdata_q      <= '0;
            m_pslverr_q     <= 1'b0;
            busy_q          <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            grant_q         <= grant_d;
            count_q         <= count_d;
            s_psel_q        <= s_psel_d;
            s_penable_q     <= s_penable_d;
            s_pwrite_q      <= s_pwrite_d;
            s_paddr_q       <= s_paddr_d;
            s_pwdata_q      <= s_pwdata_d;
            s_pstrb_q       <= s_pstrb_d;
            m_pready_q      <= m_pready_d;
            m_prdata_q      <= m_prdata_d;
            m_pslverr_q     <= m_pslverr_d;
            busy_q          <= busy_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign m_pready      = m_pready_q;
    assign m_prdata      = m_prdata_q;
    assign m_pslverr     = m_pslverr_q;
    assign s_psel        = s_psel_q;
    assign s_penable     = s_penable_q;
    assign s_pwrite      = s_pwrite_q;
    assign s_paddr       = s_paddr_q;
    assign s_pwdata      = s_pwdata_q;
    assign s_pstrb       = s_pstrb_q;
    assign busy          = busy_q;
    assign grant_idx     = grant_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: a scoreboard of expected completions is
// filled as requests are driven and drained whenever m_pready fires.
module tb_apb_rr_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;
    localparam int GW = 1;

    logic              pclk = 1'b0;
    logic              preset_n;
    logic [NR-1:0]     m_psel, m_penable, m_pwrite;
    logic [NR*AW-1:0]  m_paddr;
    logic [NR*DW-1:0]  m_pwdata;
    logic [NR*SW-1:0]  m_pstrb;
    logic [NR-1:0]     m_pready;
    logic [DW-1:0]     m_prdata;
    logic              m_pslverr;
    logic              s_psel, s_penable, s_pwrite;
    logic [AW-1:0]     s_paddr;
    logic [DW-1:0]     s_pwdata;
    logic [SW-1:0]     s_pstrb;
    logic [DW-1:0]     s_prdata;
    logic              s_pready;
    logic              s_pslverr;
    logic              busy;
    logic [GW-1:0]     grant_idx;
    logic              timeout_pulse;

    always #5 pclk = ~pclk;

    apb_rr_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .pclk(pclk), .preset_n(preset_n),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
        .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
        .busy(busy), .grant_idx(grant_idx), .timeout_pulse(timeout_pulse)
    );

    // Downstream slave model: ready after wait_states access cycles unless dead.
    int            wait_states;
    logic          slave_dead, force_rdy, slave_err;
    logic [DW-1:0] slave_rdata;
    int            acc_cnt;

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n)                              acc_cnt <= 0;
        else if (s_psel && s_penable && !s_pready)  acc_cnt <= acc_cnt + 1;
        else                                        acc_cnt <= 0;
    end

    assign s_pready  = force_rdy || (s_psel && s_penable && !slave_dead && acc_cnt == wait_states);
    assign s_prdata  = slave_rdata;
    assign s_pslverr = slave_err;

    typedef struct {
        int            idx;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [DW-1:0] rdata;
        logic          err;
        logic          tout;
        int            acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_errors = 0;
    int   acc_len  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, input logic [DW-1:0] rd, input logic err,
                       input logic tout, input int acc);
        exp_t e;
        m_psel[i]              = 1'b1;
        m_penable[i]           = 1'b1;
        m_pwrite[i]            = w;
        m_paddr[i*AW +: AW]    = a;
        m_pwdata[i*DW +: DW]   = d;
        m_pstrb[i*SW +: SW]    = s;
        e = '{idx: i, write: w, addr: a, wdata: d, strb: s, rdata: rd, err: err, tout: tout, acc: acc};
        sb.push_back(e);
    endtask

    task automatic drop(input int i);
        m_psel[i]    = 1'b0;
        m_penable[i] = 1'b0;
    endtask

    // Counts rising edges from the request cycle (cycle 0) to the m_pready cycle.
    task automatic wait_pready(output int lat, output logic [NR-1:0] who);
        bit seen = 1'b0;
        lat = 0;
        who = '0;
        while (!seen && lat < 50) begin
            @(posedge pclk);
            lat++;
            @(negedge pclk);
            if (m_pready != '0) begin
                seen = 1'b1;
                who  = m_pready;
            end
        end
        if (!seen) check("wait_pready_bound", 64'(seen), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_pready"}, 64'(m_pready), 64'd0);
        check({tag, "_m_prdata"}, 64'(m_prdata), 64'd0);
        check({tag, "_m_pslverr"}, 64'(m_pslverr), 64'd0);
        check({tag, "_s_ctrl"}, 64'({s_psel, s_penable, s_pwrite}), 64'd0);
        check({tag, "_s_paddr"}, 64'(s_paddr), 64'd0);
        check({tag, "_s_pwdata"}, 64'(s_pwdata), 64'd0);
        check({tag, "_s_pstrb"}, 64'(s_pstrb), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_grant_idx"}, 64'(grant_idx), 64'd0);
        check({tag, "_timeout_pulse"}, 64'(timeout_pulse), 64'd0);
    endtask

    // Scoreboard monitor: downstream fields follow the head entry, completions pop it.
    always @(negedge pclk) begin
        logic [NR-1:0] exp_pready;
        if (!preset_n) begin
            acc_len = 0;
        end else begin
            if (s_psel) begin
                if (sb.size() == 0) begin
                    check("spurious_s_psel", 64'(s_psel), 64'd0);
                end else begin
                    cur = sb[0];
                    check("s_paddr", 64'(s_paddr), 64'(cur.addr));
                    check("s_pwdata", 64'(s_pwdata), 64'(cur.wdata));
                    check("s_pstrb", 64'(s_pstrb), 64'(cur.strb));
                    check("s_pwrite", 64'(s_pwrite), 64'(cur.write));
                end
                if (s_penable) acc_len++;
            end
            if (m_pready != '0) begin
                if (sb.size() == 0) begin
                    check("spurious_m_pready", 64'(m_pready), 64'd0);
                end else begin
                    cur = sb.pop_front();
                    exp_pready = '0;
                    exp_pready[cur.idx] = 1'b1;
                    check("m_pready_onehot", 64'(m_pready), 64'(exp_pready));
                    check("grant_idx", 64'(grant_idx), 64'(cur.idx));
                    check("m_prdata", 64'(m_prdata), 64'(cur.rdata));
                    check("m_pslverr", 64'(m_pslverr), 64'(cur.err));
                    check("timeout_pulse", 64'(timeout_pulse), 64'(cur.tout));
                    check("access_len", 64'(acc_len), 64'(cur.acc));
                end
                acc_len = 0;
            end else begin
                check("resp_outside_done", 64'({timeout_pulse, m_pslverr, m_prdata}), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            lat;
        logic [NR-1:0] who;

        preset_n    = 1'b0;
        m_psel      = '0;
        m_penable   = '0;
        m_pwrite    = '0;
        m_paddr     = '0;
        m_pwdata    = '0;
        m_pstrb     = '0;
        wait_states = 0;
        slave_dead  = 1'b0;
        force_rdy   = 1'b0;
        slave_err   = 1'b0;
        slave_rdata = '0;

        repeat (2) @(posedge pclk);
        #1;
        check_reset_outputs("reset");
        preset_n = 1'b1;

        // Zero-wait write from req0; slave holds pready high even in SETUP/IDLE.
        force_rdy   = 1'b1;
        slave_rdata = 32'hCAFE_0000;
        req(0, 1'b1, 32'h400, 32'hDEAD_BEEF, 4'hF, 32'hCAFE_0000, 1'b0, 1'b0, 1);
        wait_pready(lat, who);
        check("A_latency", 64'(lat), 64'd3);
        check("A_who", 64'(who), 64'b01);
        check("A_busy_done", 64'(busy), 64'd1);
        drop(0);
        force_rdy = 1'b0;
        tick();
        check("A_busy_idle", 64'(busy), 64'd0);

        // Read from req1 with three wait states.
        wait_states = 3;
        slave_rdata = 32'h1234_5678;
        req(1, 1'b0, 32'h800, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 4);
        wait_pready(lat, who);
        check("B_latency", 64'(lat), 64'd6);
        check("B_who", 64'(who), 64'b10);
        drop(1);
        wait_states = 0;
        tick();

        // Both requesters continuously busy: alternating grants, 4-cycle spacing.
        slave_rdata = 32'hA5A5_0001;
        req(0, 1'b1, 32'h1000, 32'h11, 4'hF, 32'hA5A5_0001, 1'b0, 1'b0, 1);
        req(1, 1'b1, 32'h2000, 32'h22, 4'h3, 32'hA5A5_0001, 1'b0, 1'b0, 1);
        for (int t = 0; t < 4; t++) begin
            wait_pready(lat, who);
            check("C_latency", 64'(lat), 64'd3);
            check("C_who", 64'(who), (t % 2 == 0) ? 64'b01 : 64'b10);
            if (t == 0) req(0, 1'b1, 32'h1004, 32'h33, 4'hF, 32'hA5A5_0001, 1'b0, 1'b0, 1);
            if (t == 1) req(1, 1'b0, 32'h2004, 32'h44, 4'hC, 32'hA5A5_0001, 1'b0, 1'b0, 1);
            if (t == 2) drop(0);
            if (t == 3) drop(1);
            tick();
        end

        // Dead slave times out req0; queued req1 then completes normally.
        slave_dead  = 1'b1;
        slave_rdata = 32'h5555_AAAA;
        req(0, 1'b0, 32'h3000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, TO);
        req(1, 1'b0, 32'h3004, 32'h0, 4'h0, 32'h5555_AAAA, 1'b0, 1'b0, 1);
        wait_pready(lat, who);
        check("D_timeout_latency", 64'(lat), 64'(TO + 2));
        check("D_who", 64'(who), 64'b01);
        check("D_timeout_pulse", 64'(timeout_pulse), 64'd1);
        slave_dead = 1'b0;
        drop(0);
        tick();
        check("D_pulse_cleared", 64'(timeout_pulse), 64'd0);
        wait_pready(lat, who);
        check("D_next_latency", 64'(lat), 64'd3);
        check("D_next_who", 64'(who), 64'b10);
        drop(1);
        tick();

        // Slave error with ready: pslverr passes through, no timeout pulse.
        slave_err   = 1'b1;
        slave_rdata = 32'h0BAD_0BAD;
        req(0, 1'b1, 32'h4000, 32'h77, 4'h1, 32'h0BAD_0BAD, 1'b1, 1'b0, 1);
        wait_pready(lat, who);
        check("E_latency", 64'(lat), 64'd3);
        check("E_who", 64'(who), 64'b01);
        check("E_no_timeout", 64'(timeout_pulse), 64'd0);
        drop(0);
        slave_err = 1'b0;
        tick();

        // Pointer now favours req1; reset mid-access must drop it back to 0.
        wait_states = 5;
        req(1, 1'b0, 32'h5000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 6);
        tick();
        tick();
        check("F_in_access", 64'({s_psel, s_penable}), 64'b11);
        preset_n = 1'b0;
        #1;
        sb.delete();
        check_reset_outputs("F_async");
        tick();
        wait_states = 0;
        slave_rdata = 32'h7777_0000;
        req(0, 1'b1, 32'h6000, 32'h99, 4'hF, 32'h7777_0000, 1'b0, 1'b0, 1);
        req(1, 1'b0, 32'h5000, 32'h0, 4'h0, 32'h7777_0000, 1'b0, 1'b0, 1);
        preset_n = 1'b1;
        wait_pready(lat, who);
        check("F_first_latency", 64'(lat), 64'd3);
        check("F_first_who", 64'(who), 64'b01);
        drop(0);
        tick();
        wait_pready(lat, who);
        check("F_second_who", 64'(who), 64'b10);
        drop(1);
        tick();
        tick();
        check("F_queue_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
